// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response bus between alu_arbiter and its environment.
//   slave  : arbiter side (drives out_*, samples in_*)
//   master : environment side (drives in_*, samples out_*)
//   Requester i owns slice i of every flattened per-requester bus.
interface alu_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [NREQ-1:0]       in_req_valid;
   logic [NREQ-1:0]       out_req_ready;
   logic [NREQ*WIDTH-1:0] in_req_a;
   logic [NREQ*WIDTH-1:0] in_req_b;
   logic [NREQ*3-1:0]     in_req_op;
   logic [WIDTH-1:0]      out_alu_a;
   logic [WIDTH-1:0]      out_alu_b;
   logic [2:0]            out_alu_op;
   logic [WIDTH-1:0]      in_alu_result;
   logic                  in_alu_zero;
   logic [NREQ-1:0]       out_rsp_valid;
   logic [NREQ-1:0]       in_rsp_ready;
   logic [IW-1:0]         out_rsp_id;
   logic [WIDTH-1:0]      out_rsp_result;
   logic                  out_rsp_zero;
   logic                  out_rsp_neg;
   logic                  out_rsp_err;
   logic                  out_busy;
   modport slave (
      input  in_req_valid, in_req_a, in_req_b, in_req_op, in_alu_result, in_alu_zero, in_rsp_ready,
      output out_req_ready, out_alu_a, out_alu_b, out_alu_op, out_rsp_valid, out_rsp_id,
             out_rsp_result, out_rsp_zero, out_rsp_neg, out_rsp_err, out_busy
   );
   modport master (
      output in_req_valid, in_req_a, in_req_b, in_req_op, in_alu_result, in_alu_zero, in_rsp_ready,
      input  out_req_ready, out_alu_a, out_alu_b, out_alu_op, out_rsp_valid, out_rsp_id,
             out_rsp_result, out_rsp_zero, out_rsp_neg, out_rsp_err, out_busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shares one registered ALU between NREQ requesters, one op in flight.
//   clk      : clock, all state on posedge
//   in_rst_n : asynchronous active-low reset
//   bus      : alu_arbiter_if.slave -- request channel (valid/ready, operands, opcode),
//              registered ALU operand/opcode outputs, ALU result/zero inputs,
//              tagged response channel (valid/ready, id, result, zero, neg, err), busy flag
module alu_arbiter #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          in_rst_n,
   alu_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
   state_t           r_state, w_next;
   logic [IW-1:0]    r_ptr, r_tag, w_gnt;
   logic [IW:0]      w_idx;
   logic             w_found, w_take, w_legal;
   logic [2:0]       w_op;
   logic [WIDTH-1:0] r_alu_a, r_alu_b, r_res;
   logic [2:0]       r_alu_op;
   logic             r_zero, r_neg, r_err;
   // First valid requester strictly after the last grant, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
         if (!w_found && bus.in_req_valid[w_idx[IW-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = w_idx[IW-1:0];
         end
      end
   end
   assign w_op    = bus.in_req_op[w_gnt*3 +: 3];
   assign w_legal = w_op inside {3'b100, 3'b010, 3'b001, 3'b000, 3'b111};
   assign w_take  = (r_state == IDLE) && w_found;
   // Ready is held low while reset is asserted even though the state already reads IDLE.
   assign bus.out_req_ready  = (in_rst_n && w_take) ? NREQ'(1) << w_gnt : '0;
   assign bus.out_rsp_valid  = (r_state == RESP) ? NREQ'(1) << r_tag : '0;
   assign bus.out_rsp_id     = r_tag;
   assign bus.out_rsp_result = r_res;
   assign bus.out_rsp_zero   = r_zero;
   assign bus.out_rsp_neg    = r_neg;
   assign bus.out_rsp_err    = r_err;
   assign bus.out_alu_a      = r_alu_a;
   assign bus.out_alu_b      = r_alu_b;
   assign bus.out_alu_op     = r_alu_op;
   assign bus.out_busy       = (r_state != IDLE);
   always_ff @(posedge clk or negedge in_rst_n) begin
      if (!in_rst_n) r_state <= IDLE;
      else           r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_take ? (w_legal ? EXEC : RESP) : IDLE;
         EXEC:    w_next = CAPT;
         CAPT:    w_next = RESP;
         default: w_next = bus.in_rsp_ready[r_tag] ? IDLE : RESP;
      endcase
   end
   always_ff @(posedge clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_ptr    <= IW'(NREQ - 1);
         r_tag    <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= 3'b111;
         r_res    <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_take) begin
            r_tag <= w_gnt;
            r_ptr <= w_gnt;
            if (w_legal) begin
               r_alu_a  <= bus.in_req_a[w_gnt*WIDTH +: WIDTH];
               r_alu_b  <= bus.in_req_b[w_gnt*WIDTH +: WIDTH];
               r_alu_op <= w_op;
            end else begin
               // Illegal opcode answers directly and leaves the ALU inputs untouched.
               r_res  <= '0;
               r_zero <= 1'b1;
               r_neg  <= 1'b0;
               r_err  <= 1'b1;
            end
         end
         if (r_state == CAPT) begin
            // Sign comes from the result MSB; the ALU's own neg flag is not meaningful here.
            r_res  <= bus.in_alu_result;
            r_zero <= bus.in_alu_zero;
            r_neg  <= bus.in_alu_result[WIDTH-1];
            r_err  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
   localparam int N = 2;
   localparam int W = 32;
   typedef struct packed {
      logic [1:0]  vld;
      logic        id;
      logic [31:0] res;
      logic        z, n, e;
   } rsp_t;
   localparam logic [107:0] RST_OUTS = {2'b00, 2'b00, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 3'b111};
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   alu_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
   alu_arbiter #(.NREQ(N), .WIDTH(W)) dut (.clk(clk), .in_rst_n(rst_n), .bus(bus.slave));
   int vectors = 0;
   int miscompares = 0;
   int last = 1;
   logic [31:0] ea = '0, eb = '0;
   logic [2:0]  eop = 3'b111;
   logic [31:0] alu_res = '0;
   logic        alu_z = 1'b0;
   assign bus.in_alu_result = alu_res;
   assign bus.in_alu_zero   = alu_z;
   function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
      case (op)
         3'b100:  return b + a;
         3'b010:  return a + 1;
         3'b001:  return -a;
         3'b000:  return b - a;
         default: return a;
      endcase
   endfunction
   // Registered ALU: result of the operands presented at an edge is visible after that edge.
   always @(posedge clk) begin
      alu_res <= alu_f(bus.out_alu_a, bus.out_alu_b, bus.out_alu_op);
      alu_z   <= (alu_f(bus.out_alu_a, bus.out_alu_b, bus.out_alu_op) == 32'h0);
   end
   function automatic bit is_legal(logic [2:0] op);
      return op inside {3'b100, 3'b010, 3'b001, 3'b000, 3'b111};
   endfunction
   function automatic int rr_next(int prev, logic [1:0] v);
      for (int k = 1; k <= N; k++) if (v[(prev + k) % N]) return (prev + k) % N;
      return 0;
   endfunction
   function automatic rsp_t model(int id, logic [31:0] a, logic [31:0] b, logic [2:0] op);
      rsp_t m;
      m.vld = 2'b01 << id;
      m.id  = id[0];
      m.e   = !is_legal(op);
      m.res = m.e ? 32'h0 : alu_f(a, b, op);
      m.z   = (m.res == 32'h0);
      m.n   = m.res[31];
      return m;
   endfunction
   function automatic rsp_t sample_rsp();
      return {bus.out_rsp_valid, bus.out_rsp_id, bus.out_rsp_result, bus.out_rsp_zero, bus.out_rsp_neg, bus.out_rsp_err};
   endfunction
   function automatic logic [107:0] all_outs();
      return {bus.out_req_ready, bus.out_rsp_valid, bus.out_rsp_id, bus.out_rsp_result, bus.out_rsp_zero,
              bus.out_rsp_neg, bus.out_rsp_err, bus.out_busy, bus.out_alu_a, bus.out_alu_b, bus.out_alu_op};
   endfunction
   task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      bus.in_req_a[id*W +: W] = a;
      bus.in_req_b[id*W +: W] = b;
      bus.in_req_op[id*3 +: 3] = op;
      bus.in_req_valid[id] = 1'b1;
   endtask
   task automatic wait_ready(output logic [1:0] gnt, output bit to);
      to  = 1'b1;
      gnt = '0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.out_req_ready != '0) begin
            gnt = bus.out_req_ready;
            to  = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask
   task automatic wait_rsp(output int lat, output bit to);
      lat = 0;
      to  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         lat++;
         if (bus.out_rsp_valid != '0) begin
            to = 1'b0;
            break;
         end
      end
   endtask
   task automatic accept(input int id);
      bus.in_rsp_ready[id] = 1'b1;
      @(posedge clk);
      #1;
      bus.in_rsp_ready[id] = 1'b0;
   endtask
   task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        output logic [1:0] gnt, output int lat, output rsp_t r, output logic [66:0] alu, output bit to);
      bit t0, t1;
      @(negedge clk);
      drive(id, a, b, op);
      wait_ready(gnt, t0);
      @(posedge clk);
      #1;
      alu = {bus.out_alu_a, bus.out_alu_b, bus.out_alu_op};
      bus.in_req_valid[id] = 1'b0;
      wait_rsp(lat, t1);
      r  = sample_rsp();
      to = t0 | t1;
      if (!t1) accept(int'(bus.out_rsp_id));
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (all_outs() !== RST_OUTS) begin
         miscompares++;
         $display("FAIL reset_outputs got %h exp %h", all_outs(), RST_OUTS);
      end
      rst_n = 1'b1;
      last = 1;
   endtask
   task automatic test_directed();
      int          ids[6] = '{0, 1, 1, 0, 0, 1};
      logic [31:0] as[6]  = '{32'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000};
      logic [31:0] bs[6]  = '{32'd7, 32'd4, 32'h1234, 32'd1, 32'd8, 32'd0};
      logic [2:0]  ops[6] = '{3'b100, 3'b000, 3'b001, 3'b100, 3'b101, 3'b111};
      logic [1:0]  gnt, eg;
      int          lat;
      rsp_t        r, m;
      logic [66:0] alu, ealu;
      bit          to;
      for (int i = 0; i < 6; i++) begin
         eg = 2'b01 << rr_next(last, 2'b01 << ids[i]);
         m  = model(ids[i], as[i], bs[i], ops[i]);
         ealu = is_legal(ops[i]) ? {as[i], bs[i], ops[i]} : {ea, eb, eop};
         do_op(ids[i], as[i], bs[i], ops[i], gnt, lat, r, alu, to);
         vectors++;
         if (to || gnt !== eg) begin miscompares++; $display("FAIL dir_grant[%0d] got %b exp %b timeout=%0d", i, gnt, eg, to); end
         vectors++;
         if (lat !== (is_legal(ops[i]) ? 3 : 1)) begin miscompares++; $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, is_legal(ops[i]) ? 3 : 1); end
         vectors++;
         if (alu !== ealu) begin miscompares++; $display("FAIL dir_alu_in[%0d] got %h exp %h", i, alu, ealu); end
         vectors++;
         if (r !== m) begin miscompares++; $display("FAIL dir_rsp[%0d] got %h exp %h", i, r, m); end
         last = ids[i];
         if (is_legal(ops[i])) {ea, eb, eop} = {as[i], bs[i], ops[i]};
      end
      vectors++;
      if (model(1, 9, 4, 3'b000) !== {2'b10, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0} || r.e !== 1'b0) begin
         miscompares++;
         $display("FAIL dir_sub_vector got %h exp %h", model(1, 9, 4, 3'b000), {2'b10, 1'b1, 32'hFFFF_FFFB, 3'b010});
      end
   endtask
   task automatic test_random();
      int          id;
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [1:0]  gnt, eg;
      int          lat;
      rsp_t        r, m;
      logic [66:0] alu, ealu;
      bit          to;
      for (int i = 0; i < 10; i++) begin
         id = int'($urandom_range(0, 1));
         a  = (i % 4 == 0) ? 32'h0 : $urandom;
         b  = $urandom;
         op = 3'($urandom);
         eg = 2'b01 << rr_next(last, 2'b01 << id);
         m  = model(id, a, b, op);
         ealu = is_legal(op) ? {a, b, op} : {ea, eb, eop};
         do_op(id, a, b, op, gnt, lat, r, alu, to);
         vectors++;
         if (to || gnt !== eg) begin miscompares++; $display("FAIL rnd_grant[%0d] got %b exp %b timeout=%0d", i, gnt, eg, to); end
         vectors++;
         if (lat !== (is_legal(op) ? 3 : 1)) begin miscompares++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, lat, is_legal(op) ? 3 : 1); end
         vectors++;
         if (alu !== ealu) begin miscompares++; $display("FAIL rnd_alu_in[%0d] got %h exp %h", i, alu, ealu); end
         vectors++;
         if (r !== m) begin miscompares++; $display("FAIL rnd_rsp[%0d] got %h exp %h", i, r, m); end
         last = id;
         if (is_legal(op)) {ea, eb, eop} = {a, b, op};
      end
   endtask
   task automatic test_alternate();
      logic [31:0] ca[2], cb[2];
      logic [2:0]  cop[2];
      int          cnt[2];
      logic [1:0]  gnt, eg;
      int          g, lat;
      rsp_t        r, m;
      logic [66:0] alu, ealu;
      bit          to;
      cnt = '{0, 0};
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         ca[i] = $urandom; cb[i] = $urandom; cop[i] = 3'($urandom);
         drive(i, ca[i], cb[i], cop[i]);
      end
      for (int t = 0; t < 8; t++) begin
         eg = 2'b01 << rr_next(last, bus.in_req_valid);
         wait_ready(gnt, to);
         vectors++;
         if (to || gnt !== eg) begin miscompares++; $display("FAIL alt_grant[%0d] got %b exp %b timeout=%0d", t, gnt, eg, to); end
         g = gnt[1] ? 1 : 0;
         m = model(g, ca[g], cb[g], cop[g]);
         ealu = is_legal(cop[g]) ? {ca[g], cb[g], cop[g]} : {ea, eb, eop};
         if (is_legal(cop[g])) {ea, eb, eop} = {ca[g], cb[g], cop[g]};
         @(posedge clk);
         #1;
         alu = {bus.out_alu_a, bus.out_alu_b, bus.out_alu_op};
         vectors++;
         if (alu !== ealu) begin miscompares++; $display("FAIL alt_alu_in[%0d] got %h exp %h", t, alu, ealu); end
         cnt[g]++;
         if (cnt[g] < 4) begin
            ca[g] = $urandom; cb[g] = $urandom; cop[g] = 3'($urandom);
            drive(g, ca[g], cb[g], cop[g]);
         end else bus.in_req_valid[g] = 1'b0;
         wait_rsp(lat, to);
         r = sample_rsp();
         vectors++;
         if (to || r !== m) begin miscompares++; $display("FAIL alt_rsp[%0d] got %h exp %h timeout=%0d", t, r, m, to); end
         if (!to) accept(g);
         last = g;
      end
   endtask
   task automatic test_hold();
      logic [1:0]  gnt, eg;
      logic [31:0] a0, b0, a1, b1;
      int          lat;
      rsp_t        m;
      bit          to;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      @(negedge clk);
      drive(0, a0, b0, 3'b100);
      eg = 2'b01 << rr_next(last, 2'b01);
      wait_ready(gnt, to);
      vectors++;
      if (to || gnt !== eg) begin miscompares++; $display("FAIL hold_grant0 got %b exp %b timeout=%0d", gnt, eg, to); end
      @(posedge clk);
      #1;
      bus.in_req_valid[0] = 1'b0;
      drive(1, a1, b1, 3'b000);
      wait_rsp(lat, to);
      vectors++;
      if (to || lat !== 3) begin miscompares++; $display("FAIL hold_latency got %0d exp 3 timeout=%0d", lat, to); end
      m = model(0, a0, b0, 3'b100);
      bus.in_rsp_ready = 2'b10;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (sample_rsp() !== m || {bus.out_req_ready, bus.out_busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL hold_stable[%0d] got rsp %h ready %b busy %b exp rsp %h ready 00 busy 1", c, sample_rsp(), bus.out_req_ready, bus.out_busy, m);
         end
      end
      bus.in_rsp_ready = 2'b00;
      accept(0);
      wait_ready(gnt, to);
      vectors++;
      if (to || gnt !== 2'b10) begin miscompares++; $display("FAIL hold_grant1 got %b exp 10 timeout=%0d", gnt, to); end
      @(posedge clk);
      #1;
      bus.in_req_valid[1] = 1'b0;
      wait_rsp(lat, to);
      m = model(1, a1, b1, 3'b000);
      vectors++;
      if (to || sample_rsp() !== m) begin miscompares++; $display("FAIL hold_rsp1 got %h exp %h timeout=%0d", sample_rsp(), m, to); end
      if (!to) accept(1);
      last = 1;
      {ea, eb, eop} = {a1, b1, 3'b000};
   endtask
   task automatic test_reset_mid();
      logic [1:0]  gnt;
      logic [31:0] a0, b0;
      int          lat;
      rsp_t        m;
      bit          to;
      a0 = $urandom; b0 = $urandom;
      @(negedge clk);
      drive(0, a0, b0, 3'b100);
      drive(1, $urandom, $urandom, 3'b010);
      wait_ready(gnt, to);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bus.out_busy !== 1'b1 || bus.out_rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_in_capt got busy %b valid %b exp busy 1 valid 00", bus.out_busy, bus.out_rsp_valid);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (all_outs() !== RST_OUTS) begin miscompares++; $display("FAIL midrst_outputs got %h exp %h", all_outs(), RST_OUTS); end
      last = 1;
      {ea, eb, eop} = {32'h0, 32'h0, 3'b111};
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(gnt, to);
      vectors++;
      if (to || gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_first_grant got %b exp 01 timeout=%0d", gnt, to); end
      @(posedge clk);
      #1;
      bus.in_req_valid[0] = 1'b0;
      wait_rsp(lat, to);
      m = model(0, a0, b0, 3'b100);
      vectors++;
      if (to || lat !== 3 || sample_rsp() !== m) begin
         miscompares++;
         $display("FAIL midrst_rsp got %h lat %0d exp %h lat 3 timeout=%0d", sample_rsp(), lat, m, to);
      end
      if (!to) accept(0);
      wait_ready(gnt, to);
      vectors++;
      if (to || gnt !== 2'b10) begin miscompares++; $display("FAIL midrst_second_grant got %b exp 10 timeout=%0d", gnt, to); end
      @(posedge clk);
      #1;
      bus.in_req_valid[1] = 1'b0;
      wait_rsp(lat, to);
      if (!to) accept(1);
      last = 1;
   endtask
   initial begin
      bus.in_req_valid = '0;
      bus.in_req_a     = '0;
      bus.in_req_b     = '0;
      bus.in_req_op    = '0;
      bus.in_rsp_ready = '0;
      #1;
      test_reset();
      test_directed();
      test_random();
      test_alternate();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete, vectors %0d miscompares %0d", vectors, miscompares);
      $fatal(1);
   end
endmodule
